// File: rtl/test_status_led_if.sv
// Status LED bundle: fixture flags in, RGB PWM drives and FSM status out.
// master = fixture/test side, slave = test_status_led.
interface test_status_led_if;
    logic       i_running;
    logic       i_passed;
    logic       o_led_r;
    logic       o_led_g;
    logic       o_led_b;
    logic [1:0] o_state;
    logic       o_done;

    modport master (
        output i_running, i_passed,
        input  o_led_r, o_led_g, o_led_b,
        input  o_state, o_done
    );

    modport slave (
        input  i_running, i_passed,
        output o_led_r, o_led_g, o_led_b,
        output o_state, o_done
    );
endinterface

// File: rtl/test_status_led.sv
// Self-test status indicator: blue blink while running, green on pass,
// red blink code on fail. Ports: i_clk, i_rst_n (async low), bus (slave).
module test_status_led #(
    parameter int CLK_FREQ    = 48_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int PWM_BITS    = 4,
    parameter int DUTY        = 4,
    parameter int FAIL_PULSES = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    test_status_led_if.slave bus
);
    localparam int HP    = CLK_FREQ / (2 * BLINK_HZ);
    localparam int DIV_W = (HP > 1) ? $clog2(HP) : 1;
    localparam int F_LEN = 2 * FAIL_PULSES + 4;
    localparam int PH_W  = $clog2(F_LEN);
    localparam int D_SAT =
        (DUTY >= 2 ** PWM_BITS) ? 2 ** PWM_BITS : DUTY;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(HP - 1);
    localparam logic [PH_W-1:0]  RUN_LST = PH_W'(1);
    localparam logic [PH_W-1:0]  FAIL_LST = PH_W'(F_LEN - 1);
    localparam logic [PH_W-1:0]  FAIL_ON = PH_W'(2 * FAIL_PULSES);
    localparam logic [PWM_BITS:0] DUTY_C = (PWM_BITS + 1)'(D_SAT);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                r_run;
    logic                r_pass;
    logic [DIV_W-1:0]    div_cnt;
    logic [PH_W-1:0]     phase;
    logic [PH_W-1:0]     ph_last;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic                tick;
    logic                entering;
    logic                pat_r;
    logic                pat_g;
    logic                pat_b;
    logic                led_r;
    logic                led_g;
    logic                led_b;

    assign tick     = (div_cnt == DIV_MAX);
    assign entering = (state_nxt != state);
    // Extra MSB so a saturated DUTY of 2**PWM_BITS means always on.
    assign pwm_on   = ({1'b0, pwm_cnt} < DUTY_C);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ph_last   = RUN_LST;
        pat_r     = 1'b0;
        pat_g     = 1'b0;
        pat_b     = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (r_run) state_nxt = S_RUN;
            end
            S_RUN: begin
                pat_b = (phase == '0);
                if (!r_run) begin
                    state_nxt = r_pass ? S_PASS : S_FAIL;
                end
            end
            S_PASS: begin
                pat_g = 1'b1;
                if (r_run) state_nxt = S_RUN;
            end
            S_FAIL: begin
                ph_last = FAIL_LST;
                pat_r   = (phase < FAIL_ON) && !phase[0];
                if (r_run) state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run   <= 1'b0;
            r_pass  <= 1'b0;
            div_cnt <= '0;
            phase   <= '0;
            pwm_cnt <= '0;
            led_r   <= 1'b0;
            led_g   <= 1'b0;
            led_b   <= 1'b0;
        end else begin
            r_run   <= bus.i_running;
            r_pass  <= bus.i_passed;
            pwm_cnt <= pwm_cnt + 1'b1;
            // Restart the blink timing so each new state's first
            // phase is a full half-period.
            if (entering) begin
                div_cnt <= '0;
                phase   <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                phase   <= (phase == ph_last) ? '0 : phase + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            led_r <= pat_r & pwm_on;
            led_g <= pat_g & pwm_on;
            led_b <= pat_b & pwm_on;
        end
    end

    assign bus.o_led_r = led_r;
    assign bus.o_led_g = led_g;
    assign bus.o_led_b = led_b;
    assign bus.o_state = state;
    assign bus.o_done  = state[1];
endmodule

// File: tb/tb_test_status_led.sv
// Scoreboard bench for test_status_led: two instances (DUTY 4 and 1)
// share stimulus; a negedge monitor pops per-cycle expectations.
module tb_test_status_led;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    test_status_led_if ifa ();
    test_status_led_if ifb ();

    test_status_led #(
        .CLK_FREQ(8), .BLINK_HZ(1), .PWM_BITS(2),
        .DUTY(4), .FAIL_PULSES(3)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifa)
    );

    test_status_led #(
        .CLK_FREQ(8), .BLINK_HZ(1), .PWM_BITS(2),
        .DUTY(1), .FAIL_PULSES(3)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifb)
    );

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       r;
        logic       g;
        logic       b;
        logic       pw;
    } exp_t;

    exp_t  q[$];
    int    tests = 0;
    int    fails = 0;
    int    ecnt = 0;
    string tag = "reset";

    task automatic chk(input string nm, input string tg,
                       input logic [1:0] st, input logic d,
                       input logic r, input logic g, input logic b,
                       input logic [1:0] est, input logic er,
                       input logic eg, input logic eb);
        logic ed;
        ed = (est == 2'd2) || (est == 2'd3);
        tests++;
        if ({st, d, r, g, b} !== {est, ed, er, eg, eb}) begin
            fails++;
            $display("FAIL %s/%s t=%0t got st=%0d done=%b rgb=%b%b%b want st=%0d done=%b rgb=%b%b%b",
                     nm, tg, $time, st, d, r, g, b,
                     est, ed, er, eg, eb);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("dut_a", e.tag, ifa.o_state, ifa.o_done,
                ifa.o_led_r, ifa.o_led_g, ifa.o_led_b,
                e.st, e.r, e.g, e.b);
            chk("dut_b", e.tag, ifb.o_state, ifb.o_done,
                ifb.o_led_r, ifb.o_led_g, ifb.o_led_b,
                e.st, e.r & e.pw, e.g & e.pw, e.b & e.pw);
        end
    end

    task automatic push(input logic [1:0] st, input logic r,
                        input logic g, input logic b);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.r   = r;
        e.g   = g;
        e.b   = b;
        // DUTY=1 with a 2-bit counter: on after edges 1,5,9,...
        e.pw  = ((ecnt - 1) % 4 == 0);
        q.push_back(e);
    endtask

    task automatic drive(input logic run, input logic pass);
        ifa.i_running = run;
        ifa.i_passed  = pass;
        ifb.i_running = run;
        ifb.i_passed  = pass;
    endtask

    // Expectation is for outputs after this edge; inputs are
    // sampled at the next edge.
    task automatic cyc(input logic run, input logic pass,
                       input logic [1:0] st, input logic r,
                       input logic g, input logic b);
        @(posedge clk);
        #1;
        ecnt++;
        push(st, r, g, b);
        drive(run, pass);
    endtask

    function automatic logic run_b(input int t);
        return ((t / 4) % 2) == 0;
    endfunction

    function automatic logic fail_r(input int u);
        int v;
        v = u % 40;
        return (v < 20) && (((v / 4) % 2) == 0);
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0);
        repeat (3) cyc(0, 0, 2'd0, 0, 0, 0);
        rst_n = 1'b1;
        ecnt  = 0;

        tag = "idle";
        repeat (19) cyc(0, 0, 2'd0, 0, 0, 0);
        cyc(1, 1, 2'd0, 0, 0, 0);

        tag = "run";
        cyc(1, 1, 2'd0, 0, 0, 0);
        cyc(1, 1, 2'd1, 0, 0, 0);
        for (int t = 0; t < 16; t++)
            cyc(t != 15, 1, 2'd1, 0, 0, run_b(t));

        tag = "pass";
        cyc(0, 1, 2'd1, 0, 0, 1);
        cyc(0, 1, 2'd2, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            cyc(i == 7, 1, 2'd2, 0, 1, 0);

        tag = "rerun";
        cyc(1, 0, 2'd2, 0, 1, 0);
        cyc(1, 0, 2'd1, 0, 1, 0);
        for (int t = 0; t < 8; t++)
            cyc(t != 7, 0, 2'd1, 0, 0, run_b(t));

        tag = "fail";
        cyc(0, 0, 2'd1, 0, 0, 1);
        cyc(0, 0, 2'd3, 0, 0, 1);
        for (int u = 0; u < 50; u++)
            cyc(0, 0, 2'd3, fail_r(u), 0, 0);

        tag = "async_rst";
        @(posedge clk);
        #1;
        ecnt++;
        push(2'd0, 0, 0, 0);
        drive(1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        ecnt = 0;

        tag = "post_rst";
        repeat (8) cyc(0, 0, 2'd0, 0, 0, 0);

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0",
                     q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
